// File: rtl/nn_report_pkg.sv
// Shared constants, serializer state encoding and result decode helpers
// for the inference-result reporting path.
package nn_report_pkg;

  localparam logic [7:0] CH_ZERO  = 8'h30;
  localparam logic [7:0] CH_QMARK = 8'h3F;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  // Classes beyond 9 are not valid digits; report them as '?'.
  function automatic logic [7:0] digit_ascii(input logic [3:0] idx);
    return (idx <= 4'd9) ? CH_ZERO + {4'd0, idx} : CH_QMARK;
  endfunction

  // Active-low segments, bit order gfedcba; non-digits show a dash.
  function automatic logic [6:0] seg7_n(input logic [3:0] idx);
    logic [6:0] seg;
    case (idx)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = 7'h3F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 serializer for one byte. o_done is combinational in the last stop-bit
// cycle so the caller can chain the next byte with no idle gap.
module uart_tx_byte
  import nn_report_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5209
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       i_start,
  input  logic [7:0] i_byte,
  output logic       o_serial,
  output logic       o_done
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(CLKS_PER_BIT - 1);

  tx_state_t      state, state_n;
  logic [TW-1:0]  tmr, tmr_n;
  logic [2:0]     bit_idx, bit_n;
  logic [7:0]     data, data_n;
  logic           serial, serial_n;
  logic           tick;

  assign tick     = (tmr == TMAX);
  assign o_serial = serial;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      tmr     <= '0;
      bit_idx <= '0;
      data    <= '0;
      serial  <= 1'b1;
    end else begin
      state   <= state_n;
      tmr     <= tmr_n;
      bit_idx <= bit_n;
      data    <= data_n;
      serial  <= serial_n;
    end
  end

  always_comb begin
    state_n  = state;
    tmr_n    = tmr;
    bit_n    = bit_idx;
    data_n   = data;
    serial_n = serial;
    o_done   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        serial_n = 1'b1;
        if (i_start) begin
          state_n  = ST_START;
          serial_n = 1'b0;
          data_n   = i_byte;
          tmr_n    = '0;
        end
      end
      ST_START: begin
        tmr_n = tick ? '0 : tmr + TW'(1);
        if (tick) begin
          state_n  = ST_DATA;
          bit_n    = 3'd0;
          serial_n = data[0];
        end
      end
      ST_DATA: begin
        tmr_n = tick ? '0 : tmr + TW'(1);
        if (tick) begin
          if (bit_idx == 3'd7) begin
            state_n  = ST_STOP;
            serial_n = 1'b1;
          end else begin
            bit_n    = bit_idx + 3'd1;
            serial_n = data[bit_idx + 3'd1];
          end
        end
      end
      ST_STOP: begin
        tmr_n = tick ? '0 : tmr + TW'(1);
        if (tick) begin
          o_done = 1'b1;
          // Chained byte: start bit begins on the same edge the stop bit ends.
          if (i_start) begin
            state_n  = ST_START;
            serial_n = 1'b0;
            data_n   = i_byte;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/nn_result_uart_tx.sv
// Reports the network's argmax class over UART TX as an ASCII digit plus
// optional CR LF. Optional 7-segment display output under RESULT_HEX7SEG_EN.
module nn_result_uart_tx
  import nn_report_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5209,
  parameter bit SEND_CRLF    = 1'b1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       i_result_valid,
  input  logic [3:0] i_result_index,
  output logic       o_tx_serial,
  output logic       o_busy,
  output logic       o_sent,
  output logic       o_overrun
`ifdef RESULT_HEX7SEG_EN
  , output logic [6:0] o_hex_n
`endif
);

  localparam logic [1:0] LAST = SEND_CRLF ? 2'd2 : 2'd0;

  logic       accept, tx_start, tx_done;
  logic [7:0] tx_byte;
  logic [1:0] byte_idx;

  // o_busy stays high through the final stop-bit cycle, so a valid there counts as overrun.
  assign accept   = i_result_valid && !o_busy;
  assign tx_start = accept || (tx_done && byte_idx != LAST);
  assign tx_byte  = accept            ? digit_ascii(i_result_index) :
                    (byte_idx == 2'd0) ? CH_CR : CH_LF;

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk      (clk),
    .resetn   (resetn),
    .i_start  (tx_start),
    .i_byte   (tx_byte),
    .o_serial (o_tx_serial),
    .o_done   (tx_done)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      o_busy    <= 1'b0;
      o_sent    <= 1'b0;
      o_overrun <= 1'b0;
      byte_idx  <= '0;
    end else begin
      o_sent <= 1'b0;
      if (accept) begin
        o_busy   <= 1'b1;
        byte_idx <= '0;
      end else if (tx_done) begin
        if (byte_idx == LAST) begin
          o_busy   <= 1'b0;
          o_sent   <= 1'b1;
          byte_idx <= '0;
        end else begin
          byte_idx <= byte_idx + 2'd1;
        end
      end
      if (i_result_valid && o_busy)
        o_overrun <= 1'b1;
    end
  end

`ifdef RESULT_HEX7SEG_EN
  always_ff @(posedge clk) begin
    if (!resetn)     o_hex_n <= 7'h7F;
    else if (accept) o_hex_n <= seg7_n(i_result_index);
  end
`endif

endmodule

// File: tb/tb_nn_result_uart_tx.sv
// Bench for nn_result_uart_tx: three instances (4 clk/bit with and without
// CR LF, 5209 clk/bit digit only) checked against a bit-level line model.
module tb_nn_result_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            resetn;
  logic [2:0]      valid, ser, busy, sent, ovr;
  logic [2:0][3:0] index;
`ifdef RESULT_HEX7SEG_EN
  logic [2:0][6:0] hex;
`endif

  int errs   = 0;
  int checks = 0;
  bit ovr_m[3];
  logic [6:0] seg_tab[16];

  nn_result_uart_tx #(.CLKS_PER_BIT(4), .SEND_CRLF(1'b1)) dut0 (
    .clk(clk), .resetn(resetn), .i_result_valid(valid[0]), .i_result_index(index[0]),
    .o_tx_serial(ser[0]), .o_busy(busy[0]), .o_sent(sent[0]), .o_overrun(ovr[0])
`ifdef RESULT_HEX7SEG_EN
    , .o_hex_n(hex[0])
`endif
  );

  nn_result_uart_tx #(.CLKS_PER_BIT(4), .SEND_CRLF(1'b0)) dut1 (
    .clk(clk), .resetn(resetn), .i_result_valid(valid[1]), .i_result_index(index[1]),
    .o_tx_serial(ser[1]), .o_busy(busy[1]), .o_sent(sent[1]), .o_overrun(ovr[1])
`ifdef RESULT_HEX7SEG_EN
    , .o_hex_n(hex[1])
`endif
  );

  nn_result_uart_tx #(.CLKS_PER_BIT(5209), .SEND_CRLF(1'b0)) dut2 (
    .clk(clk), .resetn(resetn), .i_result_valid(valid[2]), .i_result_index(index[2]),
    .o_tx_serial(ser[2]), .o_busy(busy[2]), .o_sent(sent[2]), .o_overrun(ovr[2])
`ifdef RESULT_HEX7SEG_EN
    , .o_hex_n(hex[2])
`endif
  );

  function automatic int cpb(input int s);
    return (s == 2) ? 5209 : 4;
  endfunction

  function automatic int nbytes(input int s);
    return (s == 0) ? 3 : 1;
  endfunction

  function automatic logic [7:0] exp_byte(input logic [3:0] idx, input int b);
    if (b == 1) return 8'h0D;
    if (b == 2) return 8'h0A;
    return (idx < 4'd10) ? 8'd48 + 8'(idx) : 8'd63;
  endfunction

  // Expected line level k cycles after the accepting edge.
  function automatic logic exp_line(input int s, input logic [3:0] idx, input int k);
    int c, b, j;
    logic [7:0] by;
    c = cpb(s);
    if (k >= nbytes(s) * 10 * c) return 1'b1;
    b  = k / (10 * c);
    j  = (k / c) % 10;
    by = exp_byte(idx, b);
    if (j == 0) return 1'b0;
    if (j == 9) return 1'b1;
    return by[j-1];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One frame on instance s; optional extra valid (index 3) at cycle inj_at.
  task automatic run_frame(input int s, input logic [3:0] idx, input int inj_at,
                           output logic [7:0] d0, output int zrun);
    int c, l, werr, bmis, bcnt, spos, b, j;
    bit zdone;
    logic [7:0] dec[3];
    c = cpb(s); l = nbytes(s) * 10 * c;
    werr = 0; bmis = 0; bcnt = 0; spos = -1; zrun = 0; zdone = 0;
    dec = '{default: 8'h00};
    @(negedge clk); valid[s] = 1'b1; index[s] = idx;
    @(negedge clk); valid[s] = 1'b0; index[s] = 4'($urandom);
    for (int k = 0; k < l + 4; k++) begin
      if (ser[s] !== exp_line(s, idx, k)) werr++;
      if (busy[s] !== (k < l)) bmis++;
      if (busy[s] === 1'b1) bcnt++;
      if (sent[s] === 1'b1) spos = (spos == -1) ? k : -2;
      if (!zdone && ser[s] === 1'b0) zrun++; else zdone = 1;
      if (k < l && (k % c) == c / 2) begin
        b = k / (10 * c); j = (k / c) % 10;
        if (j >= 1 && j <= 8) dec[b][j-1] = ser[s];
      end
      if (k == inj_at) begin
        valid[s] = 1'b1; index[s] = 4'd3; ovr_m[s] = 1'b1;
      end else if (k == inj_at + 1) begin
        valid[s] = 1'b0;
      end
      @(negedge clk);
    end
    chk($sformatf("wave s%0d i%0d", s, idx), werr, 0);
    chk($sformatf("busy_shape s%0d", s), bmis, 0);
    chk($sformatf("busy_len s%0d", s), bcnt, l);
    chk($sformatf("sent_pos s%0d", s), spos, l);
    for (int i = 0; i < nbytes(s); i++)
      chk($sformatf("byte%0d s%0d i%0d", i, s, idx), dec[i], exp_byte(idx, i));
    chk($sformatf("overrun s%0d", s), ovr[s], ovr_m[s]);
`ifdef RESULT_HEX7SEG_EN
    chk($sformatf("hex s%0d", s), hex[s], seg_tab[idx]);
`endif
    d0 = dec[0];
  endtask

  typedef struct {
    int         sel;
    logic [3:0] idx;
    logic [7:0] b0;
  } vec_t;

  vec_t       tbl[6];
  logic [7:0] d0;
  int         zr, bad;
  logic [3:0] ri;
  int         rs;

  initial begin
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    tbl[0] = '{0, 4'd7,  8'h37};
    tbl[1] = '{1, 4'd12, 8'h3F};
    tbl[2] = '{0, 4'd9,  8'h39};
    tbl[3] = '{1, 4'd0,  8'h30};
    tbl[4] = '{0, 4'd10, 8'h3F};
    tbl[5] = '{1, 4'd15, 8'h3F};

    resetn = 1'b0; valid = '0; index = '0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("rst_ser s%0d", s), ser[s], 1'b1);
      chk($sformatf("rst_busy s%0d", s), busy[s], 1'b0);
      chk($sformatf("rst_sent s%0d", s), sent[s], 1'b0);
      chk($sformatf("rst_ovr s%0d", s), ovr[s], 1'b0);
`ifdef RESULT_HEX7SEG_EN
      chk($sformatf("rst_hex s%0d", s), hex[s], 7'h7F);
`endif
    end
    resetn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_frame(tbl[i].sel, tbl[i].idx, -1, d0, zr);
      chk($sformatf("tbl%0d_b0", i), d0, tbl[i].b0);
    end

    for (int i = 0; i < 8; i++) begin
      ri = 4'($urandom_range(15, 0));
      rs = int'($urandom_range(1, 0));
      run_frame(rs, ri, -1, d0, zr);
    end

    // Valid 15 cycles into a frame: ignored, overrun sticks, no second frame.
    run_frame(0, 4'd5, 15, d0, zr);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      if (ser[0] !== 1'b1 || busy[0] !== 1'b0 || ovr[0] !== 1'b1) bad++;
      @(negedge clk);
    end
    chk("overrun_idle", bad, 0);

    // Valid in the final stop-bit cycle is still treated as busy.
    run_frame(1, 4'd2, 39, d0, zr);

    // Reset mid-DATA of byte 1, then a clean frame.
    @(negedge clk); valid[0] = 1'b1; index[0] = 4'd6;
    @(negedge clk); valid[0] = 1'b0;
    repeat (49) @(negedge clk);
    chk("pre_rst_busy", busy[0], 1'b1);
    resetn = 1'b0;
    @(negedge clk);
    chk("midrst_ser", ser[0], 1'b1);
    chk("midrst_busy", busy[0], 1'b0);
    chk("midrst_sent", sent[0], 1'b0);
    chk("midrst_ovr", ovr[0], 1'b0);
    ovr_m = '{default: 1'b0};
    resetn = 1'b1;
    @(negedge clk);
    run_frame(0, 4'd0, -1, d0, zr);

    // Full-rate bit timing.
    run_frame(2, 4'd9, -1, d0, zr);
    chk("start_width_5209", zr, 5209);
    chk("big_b0", d0, 8'h39);
`ifdef RESULT_HEX7SEG_EN
    chk("big_hex", hex[2], 7'b0010000);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
